// File: rtl/mips_defs_pkg.sv
// Shared MIPS definitions: the memory-access opcodes decoded in M and the default data memory depth.
package mips_defs;

  localparam int DM_WORDS_DEFAULT = 4096;

  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;

endpackage

// File: rtl/data_memory.sv
// Word-organised data memory: byte-enabled synchronous write, asynchronous read, async-low clear.
// It also prints the trace line for every committed store.
module data_memory #(
  parameter int WORDS = 4096,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  input  logic [31:0]   trace_pc,
  input  logic [31:0]   trace_addr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[addr];

`ifndef SYNTHESIS
  // wdata already carries the full merged word, so it is exactly the post-write value
  always @(posedge clk) begin
    if (reset && (be != 4'b0000))
      $display("%d@%h: *%h <= %h", $time, trace_pc, trace_addr, wdata);
  end
`endif

endmodule

// File: rtl/memory_access.sv
// M stage of the five-stage MIPS pipeline: E/M register, data memory access and load extension.
import mips_defs::*;

module memory_access #(
  parameter int DM_WORDS = DM_WORDS_DEFAULT,
  parameter int DM_AW    = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        M_en,
  input  logic        M_clr,
  input  logic [31:0] E_instr,
  input  logic [31:0] E_PC,
  input  logic [31:0] E_ALUResult,
  input  logic [31:0] E_RD2_M,
  input  logic [31:0] E_WD_M,
  input  logic [4:0]  E_A3_M,
  input  logic [31:0] M_Forward2,
  output logic [31:0] M_instr,
  output logic [31:0] M_PC,
  output logic [4:0]  M_A3,
  output logic [31:0] M_WD,
  output logic [31:0] M_RD2,
  output logic [31:0] M_Addr,
  output logic [31:0] M_WD_W
);

  localparam logic [32:0] DM_BYTES = 33'(DM_WORDS) * 33'd4;

  logic [5:0]       opcode;
  logic             is_store;
  logic             is_load;
  logic             in_range;
  logic [DM_AW-1:0] word_idx;
  logic [3:0]       byte_en;
  logic [31:0]      store_lanes;
  logic [31:0]      merged_word;
  logic [31:0]      read_word;

  function automatic logic [31:0] load_extend(input logic [5:0] op, input logic [1:0] lo,
                                              input logic [31:0] word);
    logic signed [15:0] half;
    logic signed [7:0]  byt;
    half = lo[1] ? word[31:16] : word[15:0];
    case (lo)
      2'd0:    byt = word[7:0];
      2'd1:    byt = word[15:8];
      2'd2:    byt = word[23:16];
      default: byt = word[31:24];
    endcase
    case (op)
      OP_LH:   load_extend = 32'(half);
      OP_LHU:  load_extend = {16'h0000, half};
      OP_LB:   load_extend = 32'(byt);
      OP_LBU:  load_extend = {24'h000000, byt};
      default: load_extend = word;
    endcase
  endfunction

  // E/M pipeline register boundary
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      M_instr <= '0;
      M_PC    <= '0;
      M_A3    <= '0;
      M_WD    <= '0;
      M_RD2   <= '0;
      M_Addr  <= '0;
    end else if (M_clr) begin
      M_instr <= '0;
      M_PC    <= '0;
      M_A3    <= '0;
      M_WD    <= '0;
      M_RD2   <= '0;
      M_Addr  <= '0;
    end else if (M_en) begin
      M_instr <= E_instr;
      M_PC    <= E_PC;
      M_A3    <= E_A3_M;
      M_WD    <= E_WD_M;
      M_RD2   <= E_RD2_M;
      M_Addr  <= E_ALUResult;
    end
  end

  assign opcode   = M_instr[31:26];
  assign is_store = (opcode == OP_SW) || (opcode == OP_SH) || (opcode == OP_SB);
  assign is_load  = (opcode == OP_LW) || (opcode == OP_LH) || (opcode == OP_LHU) ||
                    (opcode == OP_LB) || (opcode == OP_LBU);
  assign in_range = {1'b0, M_Addr} < DM_BYTES;
  assign word_idx = M_Addr[DM_AW+1:2];

  // Sub-word stores replicate the data across lanes; the byte enables pick the target lane
  always_comb begin
    byte_en     = 4'b0000;
    store_lanes = M_Forward2;
    if (is_store && in_range) begin
      case (opcode)
        OP_SW: byte_en = 4'b1111;
        OP_SH: begin
          byte_en     = M_Addr[1] ? 4'b1100 : 4'b0011;
          store_lanes = {2{M_Forward2[15:0]}};
        end
        default: begin
          byte_en     = 4'b0001 << M_Addr[1:0];
          store_lanes = {4{M_Forward2[7:0]}};
        end
      endcase
    end
  end

  always_comb begin
    merged_word = read_word;
    for (int b = 0; b < 4; b++) begin
      if (byte_en[b]) merged_word[8*b +: 8] = store_lanes[8*b +: 8];
    end
  end

  data_memory #(
    .WORDS (DM_WORDS),
    .AW    (DM_AW)
  ) u_dm (
    .clk        (clk),
    .reset      (reset),
    .addr       (word_idx),
    .be         (byte_en),
    .wdata      (merged_word),
    .trace_pc   (M_PC),
    .trace_addr ({M_Addr[31:2], 2'b00}),
    .rdata      (read_word)
  );

  always_comb begin
    M_WD_W = M_WD;
    if (is_load) M_WD_W = in_range ? load_extend(opcode, M_Addr[1:0], read_word) : 32'h0;
  end

endmodule
